// File: rtl/uart_frame_parser.sv
// Receive-side framing stage: hunts for SOF, parses length/payload, checks a
// mod-256 checksum and forwards the payload as an AXI-Stream packet.
module uart_frame_parser #(
    parameter logic [7:0]  SOF     = 8'h7E,
    parameter int unsigned MAX_LEN = 64,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_error,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       stat_good,
    output logic       stat_bad,
    output logic       stat_drop,
    output logic       busy
);

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_LEN     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_CHECK   = 2'd3;

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    logic [1:0]  state;
    logic [7:0]  acc;
    logic [7:0]  cnt;
    logic [7:0]  hold_data;
    logic        hold_full;
    logic [15:0] tmo_cnt;

    logic       accept;
    logic       out_free;
    logic       tmo_expired;
    logic       abort;
    logic [7:0] sum;
    logic       emit;
    logic       emit_last;
    logic       emit_user;

    assign out_free      = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = (state == ST_HUNT || state == ST_LEN) ? 1'b1 : out_free;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign busy          = (state != ST_HUNT);
    assign sum           = acc + s_axis_tdata;
    assign tmo_expired   = (TIMEOUT != 16'd0) && (tmo_cnt == TIMEOUT);

    // An accepted byte clears the timeout, so a timeout abort only fires in
    // idle cycles and waits for the output register to be free.
    assign abort = (state != ST_HUNT) &&
                   ((accept && s_axis_error) ||
                    (!accept && tmo_expired && out_free));

    always_comb begin
        emit      = 1'b0;
        emit_last = 1'b0;
        emit_user = 1'b0;
        if (abort) begin
            emit      = hold_full;
            emit_last = 1'b1;
            emit_user = 1'b1;
        end else if (accept && state == ST_PAYLOAD) begin
            emit = hold_full;
        end else if (accept && state == ST_CHECK) begin
            emit      = hold_full;
            emit_last = 1'b1;
            emit_user = (sum != 8'h00);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_HUNT;
            acc           <= '0;
            cnt           <= '0;
            hold_data     <= '0;
            hold_full     <= 1'b0;
            tmo_cnt       <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            stat_good     <= 1'b0;
            stat_bad      <= 1'b0;
            stat_drop     <= 1'b0;
        end else begin
            stat_good <= 1'b0;
            stat_bad  <= 1'b0;
            stat_drop <= 1'b0;

            if (accept || state == ST_HUNT) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != TIMEOUT) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end

            // Consume first; a load in the same cycle overrides (no bubble).
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (emit) begin
                m_axis_tdata  <= hold_data;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= emit_last;
                m_axis_tuser  <= emit_user;
            end

            if (abort) begin
                hold_full <= 1'b0;
                stat_bad  <= 1'b1;
                state     <= ST_HUNT;
            end else if (accept) begin
                case (state)
                    ST_HUNT: begin
                        if (!s_axis_error && s_axis_tdata == SOF) begin
                            acc   <= '0;
                            state <= ST_LEN;
                        end else begin
                            stat_drop <= 1'b1;
                        end
                    end
                    ST_LEN: begin
                        acc <= sum;
                        if (s_axis_tdata == 8'd0) begin
                            state <= ST_CHECK;
                        end else if (s_axis_tdata <= MAX_LEN_B) begin
                            cnt   <= s_axis_tdata;
                            state <= ST_PAYLOAD;
                        end else begin
                            stat_bad <= 1'b1;
                            state    <= ST_HUNT;
                        end
                    end
                    ST_PAYLOAD: begin
                        acc       <= sum;
                        cnt       <= cnt - 8'd1;
                        hold_data <= s_axis_tdata;
                        hold_full <= 1'b1;
                        if (cnt == 8'd1) begin
                            state <= ST_CHECK;
                        end
                    end
                    default: begin
                        hold_full <= 1'b0;
                        if (sum == 8'h00) begin
                            stat_good <= 1'b1;
                        end else begin
                            stat_bad <= 1'b1;
                        end
                        state <= ST_HUNT;
                    end
                endcase
            end
        end
    end

endmodule
